// File: rtl/fport_reader.sv
// Debounced input port: 2-FF synchronizer, stability-window filter, valid/ack handshake.
// Optional sticky overrun flag when FPORT_READER_OVERRUN_EN is defined.
module fport_reader #(
    parameter int unsigned       WIDTH         = 4,
    parameter logic [WIDTH-1:0]  PATTERN       = 4'b1010,
    parameter int unsigned       STABLE_CYCLES = 4,
    parameter int unsigned       CW            = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             changed,
    output logic             match
`ifdef FPORT_READER_OVERRUN_EN
    ,
    output logic             overrun
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;
    logic             match_q, match_d;
    logic             overrun_q, overrun_d;
    logic             commit;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sync2_q != cand_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = IDLE;
                    // A glitch that settles back to the published value is not a commit.
                    commit  = (cand_q != data_out_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        data_out_d = commit ? cand_q : data_out_q;
        changed_d  = commit;
        valid_d    = commit | (valid_q & ~ack);
        match_d    = (data_out_q == PATTERN);
        overrun_d  = overrun_q | (commit & valid_q & ~ack);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q    <= IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            match_q    <= (PATTERN == '0);
            overrun_q  <= 1'b0;
        end else begin
            sync1_q    <= data_in;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            match_q    <= match_d;
            overrun_q  <= overrun_d;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign changed  = changed_q;
    assign match    = match_q;

`ifdef FPORT_READER_OVERRUN_EN
    assign overrun = overrun_q;
`else
    logic unused_overrun;
    assign unused_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_fport_reader.sv
// Bench for fport_reader: table of settled values plus hand-written corner sequences,
// with a queue of expected commits checked against every changed pulse.
module tb_fport_reader;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] data_in;
    logic       ack;
    logic [3:0] data_out;
    logic       valid;
    logic       changed;
    logic       match;
`ifdef FPORT_READER_OVERRUN_EN
    logic       overrun;
`endif

    fport_reader #(
        .WIDTH(4),
        .PATTERN(4'b1010),
        .STABLE_CYCLES(4),
        .CW(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .data_in(data_in),
        .ack(ack),
        .data_out(data_out),
        .valid(valid),
        .changed(changed),
        .match(match)
`ifdef FPORT_READER_OVERRUN_EN
        ,
        .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] val;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [3:0] din;
        logic [3:0] dout;
        logic       mat;
        logic       commit;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // One clock edge; outputs are sampled 1ns later and every changed pulse is scored.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rstn && changed === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_changed", 32'(changed), 32'd0);
            end else begin
                e = sb.pop_front();
                check("commit_value", 32'(data_out), 32'(e.val));
                check("commit_cycle", 32'(cyc), 32'(e.cyc));
                check("commit_valid", 32'(valid), 32'd1);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Expect a commit of v on e6 counted from the edge after this drive.
    task automatic expect_commit(input logic [3:0] v);
        exp_t e;
        e.val = v;
        e.cyc = cyc + 7;
        sb.push_back(e);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{din: 4'b1010, dout: 4'b1010, mat: 1'b1, commit: 1'b1};
        vecs[1] = '{din: 4'b1010, dout: 4'b1010, mat: 1'b1, commit: 1'b0};
        vecs[2] = '{din: 4'b1111, dout: 4'b1111, mat: 1'b0, commit: 1'b1};
        vecs[3] = '{din: 4'b0000, dout: 4'b0000, mat: 1'b0, commit: 1'b1};
        vecs[4] = '{din: 4'b0110, dout: 4'b0110, mat: 1'b0, commit: 1'b1};
        vecs[5] = '{din: 4'b1010, dout: 4'b1010, mat: 1'b1, commit: 1'b1};

        // Reset with all inputs high
        rstn    = 1'b0;
        ack     = 1'b0;
        data_in = 4'b1111;
        ticks(3);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_changed", 32'(changed), 32'd0);
        check("rst_match", 32'(match), 32'd0);
`ifdef FPORT_READER_OVERRUN_EN
        check("rst_overrun", 32'(overrun), 32'd0);
`endif
        rstn = 1'b1;
        expect_commit(4'b1111);
        ticks(6);
        check("rel_before_commit", 32'(data_out), 32'd0);
        tick();
        check("rel_data_out", 32'(data_out), 32'hf);
        tick();
        check("rel_pulse_one_cycle", 32'(changed), 32'd0);
        do_ack();
        check("rel_ack_valid", 32'(valid), 32'd0);

        // Pattern: commit at e6, match at e7, ack at e8
        data_in = 4'b1010;
        expect_commit(4'b1010);
        ticks(7);
        check("pat_valid_e6", 32'(valid), 32'd1);
        check("pat_match_e6", 32'(match), 32'd0);
        tick();
        check("pat_match_e7", 32'(match), 32'd1);
        check("pat_changed_e7", 32'(changed), 32'd0);
        do_ack();
        check("pat_valid_after_ack", 32'(valid), 32'd0);
        do_ack();
        check("pat_ack_idle", 32'(valid), 32'd0);

        // Glitch back to the published value
        data_in = 4'b0000;
        ticks(2);
        data_in = 4'b1010;
        ticks(12);
        check("glitch_data_out", 32'(data_out), 32'ha);
        check("glitch_valid", 32'(valid), 32'd0);
        check("glitch_match", 32'(match), 32'd1);

        // Restart the window before the first value settles
        data_in = 4'b0011;
        ticks(3);
        data_in = 4'b0101;
        expect_commit(4'b0101);
        ticks(10);
        check("restart_data_out", 32'(data_out), 32'h5);
        check("restart_valid", 32'(valid), 32'd1);

        // Ack lands on the commit edge of a new value
        data_in = 4'b1100;
        expect_commit(4'b1100);
        ticks(6);
        check("coll_pre_data_out", 32'(data_out), 32'h5);
        do_ack();
        check("coll_valid", 32'(valid), 32'd1);
        check("coll_data_out", 32'(data_out), 32'hc);
`ifdef FPORT_READER_OVERRUN_EN
        check("coll_overrun", 32'(overrun), 32'd0);
`endif
        do_ack();
        check("coll_ack_clears", 32'(valid), 32'd0);

        // Second commit with the first never acked
        data_in = 4'b0001;
        expect_commit(4'b0001);
        ticks(9);
`ifdef FPORT_READER_OVERRUN_EN
        check("ovr_after_first", 32'(overrun), 32'd0);
`endif
        data_in = 4'b0010;
        expect_commit(4'b0010);
        ticks(6);
`ifdef FPORT_READER_OVERRUN_EN
        check("ovr_before_second", 32'(overrun), 32'd0);
`endif
        tick();
        check("ovr_data_out", 32'(data_out), 32'h2);
        check("ovr_valid", 32'(valid), 32'd1);
`ifdef FPORT_READER_OVERRUN_EN
        check("ovr_set", 32'(overrun), 32'd1);
        do_ack();
        check("ovr_sticky_ack", 32'(overrun), 32'd1);
`else
        do_ack();
`endif
        check("ovr_ack_valid", 32'(valid), 32'd0);

        // Reset mid-run, then table of settled values
        data_in = 4'b0000;
        rstn    = 1'b0;
        #2;
        check("rst2_data_out", 32'(data_out), 32'd0);
        check("rst2_match", 32'(match), 32'd0);
`ifdef FPORT_READER_OVERRUN_EN
        check("rst2_overrun", 32'(overrun), 32'd0);
`endif
        ticks(2);
        rstn = 1'b1;
        ticks(10);
        check("rst2_quiet_valid", 32'(valid), 32'd0);

        for (int i = 0; i < 6; i++) begin
            data_in = vecs[i].din;
            if (vecs[i].commit) expect_commit(vecs[i].din);
            ticks(9);
            check($sformatf("vec%0d_data_out", i), 32'(data_out), 32'(vecs[i].dout));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].commit));
            check($sformatf("vec%0d_match", i), 32'(match), 32'(vecs[i].mat));
            do_ack();
            check($sformatf("vec%0d_ack", i), 32'(valid), 32'd0);
        end

        ticks(3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
